// File: rtl/wb_regfile.sv
// Writeback register file with per-register pending-write scoreboard.
// Reads are combinational with optional writeback forwarding.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module wb_regfile #(
   parameter int BYPASS = 1,
   parameter int W      = `WORD_WIDTH
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         WB_En,
   input  logic [4:0]   WB_Addr,
   input  logic [W-1:0] WB_Data,
   input  logic [4:0]   RA_Addr,
   input  logic [4:0]   RB_Addr,
   input  logic         RA_Use,
   input  logic         RB_Use,
   output logic [W-1:0] RA_Data,
   output logic [W-1:0] RB_Data,
   input  logic         Issue_En,
   input  logic [4:0]   Issue_Dst,
   output logic         Stall,
   output logic         Issue_Err,
   output logic         WB_Err
);

   logic [W-1:0] rf_q  [32];
   logic [W-1:0] rf_d  [32];
   logic [1:0]   cnt_q [32];
   logic [1:0]   cnt_d [32];
   logic         iss_err_q, iss_err_d;
   logic         wb_err_q, wb_err_d;
   logic         inc, dec, same;
   logic         byp_a, byp_b;
   logic         haz_a, haz_b;

   assign dec  = WB_En & (WB_Addr != 5'd0);
   assign inc  = Issue_En & (Issue_Dst != 5'd0) & ~Stall;
   assign same = inc & dec & (Issue_Dst == WB_Addr);

   assign byp_a = (BYPASS != 0) & dec & (WB_Addr == RA_Addr);
   assign byp_b = (BYPASS != 0) & dec & (WB_Addr == RB_Addr);

   assign RA_Data = byp_a ? WB_Data :
                    (RA_Addr == 5'd0) ? '0 : rf_q[RA_Addr];
   assign RB_Data = byp_b ? WB_Data :
                    (RB_Addr == 5'd0) ? '0 : rf_q[RB_Addr];

   // A last pending write arriving right now is forwarded, so no hold.
   assign haz_a = RA_Use & (RA_Addr != 5'd0) &
                  (cnt_q[RA_Addr] != 2'd0) &
                  ~(byp_a & (cnt_q[RA_Addr] == 2'd1));
   assign haz_b = RB_Use & (RB_Addr != 5'd0) &
                  (cnt_q[RB_Addr] != 2'd0) &
                  ~(byp_b & (cnt_q[RB_Addr] == 2'd1));

   assign Stall     = haz_a | haz_b;
   assign Issue_Err = iss_err_q;
   assign WB_Err    = wb_err_q;

   always_comb begin
      rf_d      = rf_q;
      cnt_d     = cnt_q;
      iss_err_d = iss_err_q;
      wb_err_d  = wb_err_q;
      if (dec) begin
         rf_d[WB_Addr] = WB_Data;
      end
      if (inc & ~same) begin
         if (cnt_q[Issue_Dst] == 2'd3) begin
            iss_err_d = 1'b1;
         end else begin
            cnt_d[Issue_Dst] = cnt_q[Issue_Dst] + 2'd1;
         end
      end
      if (dec & ~same) begin
         if (cnt_q[WB_Addr] == 2'd0) begin
            wb_err_d = 1'b1;
         end else begin
            cnt_d[WB_Addr] = cnt_q[WB_Addr] - 2'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         iss_err_q <= 1'b0;
         wb_err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i]  <= rf_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         iss_err_q <= iss_err_d;
         wb_err_q  <= wb_err_d;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one forwarding instance and
// one non-forwarding instance share the same stimulus.
module tb_wb_regfile;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RST;
   logic         WB_En;
   logic [4:0]   WB_Addr;
   logic [W-1:0] WB_Data;
   logic [4:0]   RA_Addr, RB_Addr;
   logic         RA_Use, RB_Use;
   logic         Issue_En;
   logic [4:0]   Issue_Dst;

   logic [W-1:0] ra1, rb1, ra0, rb0;
   logic         st1, ie1, we1, st0, ie0, we0;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   wb_regfile #(.BYPASS(1), .W(W)) u_byp (
      .CLK(CLK), .RST(RST),
      .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
      .RA_Addr(RA_Addr), .RB_Addr(RB_Addr),
      .RA_Use(RA_Use), .RB_Use(RB_Use),
      .RA_Data(ra1), .RB_Data(rb1),
      .Issue_En(Issue_En), .Issue_Dst(Issue_Dst),
      .Stall(st1), .Issue_Err(ie1), .WB_Err(we1)
   );

   wb_regfile #(.BYPASS(0), .W(W)) u_nobyp (
      .CLK(CLK), .RST(RST),
      .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
      .RA_Addr(RA_Addr), .RB_Addr(RB_Addr),
      .RA_Use(RA_Use), .RB_Use(RB_Use),
      .RA_Data(ra0), .RB_Data(rb0),
      .Issue_En(Issue_En), .Issue_Dst(Issue_Dst),
      .Stall(st0), .Issue_Err(ie0), .WB_Err(we0)
   );

   task automatic chk(input string tag,
                      input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      WB_En     = 1'b0;
      WB_Addr   = 5'd0;
      WB_Data   = '0;
      RA_Addr   = 5'd0;
      RB_Addr   = 5'd0;
      RA_Use    = 1'b0;
      RB_Use    = 1'b0;
      Issue_En  = 1'b0;
      Issue_Dst = 5'd0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      idle();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;

      // reset state
      RA_Addr = 5'd5; RB_Addr = 5'd31;
      RA_Use = 1'b1; RB_Use = 1'b1;
      #1;
      chk("rst_ra", ra1, 32'h0);
      chk("rst_rb", rb1, 32'h0);
      chk("rst_stall", {31'b0, st1}, 32'h0);
      chk("rst_ierr", {31'b0, ie1}, 32'h0);
      chk("rst_werr", {31'b0, we1}, 32'h0);

      // write reg5, then write to reg0
      idle();
      WB_En = 1'b1; WB_Addr = 5'd5; WB_Data = 32'h1234;
      RA_Addr = 5'd1;
      tick();
      idle();
      WB_En = 1'b1; WB_Addr = 5'd0; WB_Data = 32'hFFFF;
      RA_Addr = 5'd5; RB_Addr = 5'd0;
      #1;
      chk("wr_r5", ra1, 32'h1234);
      chk("wr0_byp_rb", rb1, 32'h0);
      chk("wr_werr", {31'b0, we1}, 32'h1);
      tick();
      idle();
      RA_Addr = 5'd0; RB_Addr = 5'd5;
      #1;
      chk("r0_zero", ra1, 32'h0);
      chk("r5_rb", rb1, 32'h1234);

      // forwarding vs. no forwarding
      idle();
      WB_En = 1'b1; WB_Addr = 5'd7; WB_Data = 32'h11;
      tick();
      idle();
      WB_En = 1'b1; WB_Addr = 5'd7; WB_Data = 32'hAA;
      RA_Addr = 5'd7; RB_Addr = 5'd7;
      #1;
      chk("byp1_ra", ra1, 32'hAA);
      chk("byp1_rb", rb1, 32'hAA);
      chk("byp0_ra", ra0, 32'h11);
      chk("byp0_rb", rb0, 32'h11);
      tick();
      idle();
      RA_Addr = 5'd7;
      #1;
      chk("after_byp1", ra1, 32'hAA);
      chk("after_byp0", ra0, 32'hAA);

      // reset clears data and error flags
      RST = 1'b1;
      tick();
      RST = 1'b0;
      idle();
      RA_Addr = 5'd5; RB_Addr = 5'd7;
      #1;
      chk("rst2_r5", ra1, 32'h0);
      chk("rst2_r7", rb1, 32'h0);
      chk("rst2_werr", {31'b0, we1}, 32'h0);

      // RAW hazard on reg3
      idle();
      Issue_En = 1'b1; Issue_Dst = 5'd3;
      tick();
      idle();
      RA_Addr = 5'd3; RA_Use = 1'b1;
      #1;
      chk("haz_st1", {31'b0, st1}, 32'h1);
      chk("haz_st0", {31'b0, st0}, 32'h1);
      tick();
      WB_En = 1'b1; WB_Addr = 5'd3; WB_Data = 32'h33;
      #1;
      chk("haz_clr_st1", {31'b0, st1}, 32'h0);
      chk("haz_clr_st0", {31'b0, st0}, 32'h1);
      chk("haz_clr_ra1", ra1, 32'h33);
      tick();
      WB_En = 1'b0;
      #1;
      chk("haz_done_st1", {31'b0, st1}, 32'h0);
      chk("haz_done_st0", {31'b0, st0}, 32'h0);
      chk("haz_done_ra", ra1, 32'h33);
      chk("haz_werr", {31'b0, we1}, 32'h0);

      // simultaneous issue and writeback to reg4
      idle();
      Issue_En = 1'b1; Issue_Dst = 5'd4;
      tick();
      WB_En = 1'b1; WB_Addr = 5'd4; WB_Data = 32'h44;
      tick();
      idle();
      RB_Addr = 5'd4; RB_Use = 1'b1;
      #1;
      chk("sim_st1", {31'b0, st1}, 32'h1);
      chk("sim_st0", {31'b0, st0}, 32'h1);
      chk("sim_rb", rb1, 32'h44);
      WB_En = 1'b1; WB_Addr = 5'd4; WB_Data = 32'h45;
      #1;
      chk("sim_clr_st1", {31'b0, st1}, 32'h0);
      tick();
      idle();
      RB_Addr = 5'd4; RB_Use = 1'b1;
      #1;
      chk("sim_done_st1", {31'b0, st1}, 32'h0);
      chk("sim_werr", {31'b0, we1}, 32'h0);

      // counter saturation on reg9
      idle();
      Issue_En = 1'b1; Issue_Dst = 5'd9;
      tick();
      tick();
      tick();
      #1;
      chk("sat3_ierr", {31'b0, ie1}, 32'h0);
      tick();
      Issue_En = 1'b0;
      #1;
      chk("sat4_ierr1", {31'b0, ie1}, 32'h1);
      chk("sat4_ierr0", {31'b0, ie0}, 32'h1);
      RA_Addr = 5'd9; RA_Use = 1'b1;
      WB_En = 1'b1; WB_Addr = 5'd9; WB_Data = 32'h99;
      #1;
      chk("sat_st_byp", {31'b0, st1}, 32'h1);
      tick();
      idle();
      WB_En = 1'b1; WB_Addr = 5'd2; WB_Data = 32'h22;
      tick();
      idle();
      RA_Addr = 5'd2;
      #1;
      chk("underflow_werr", {31'b0, we1}, 32'h1);
      chk("underflow_data", ra1, 32'h22);
      chk("ierr_sticky", {31'b0, ie1}, 32'h1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      chk("err_rst_ierr", {31'b0, ie1}, 32'h0);
      chk("err_rst_werr", {31'b0, we1}, 32'h0);

      // reset during pending writes on reg6
      idle();
      Issue_En = 1'b1; Issue_Dst = 5'd6;
      tick();
      idle();
      WB_En = 1'b1; WB_Addr = 5'd6; WB_Data = 32'h55;
      tick();
      idle();
      Issue_En = 1'b1; Issue_Dst = 5'd6;
      tick();
      tick();
      idle();
      RA_Addr = 5'd6; RA_Use = 1'b1;
      #1;
      chk("mid_pre_st", {31'b0, st1}, 32'h1);
      chk("mid_pre_ra", ra1, 32'h55);
      RST = 1'b1;
      WB_En = 1'b1; WB_Addr = 5'd6; WB_Data = 32'h77;
      Issue_En = 1'b1; Issue_Dst = 5'd6;
      RA_Use = 1'b0;
      tick();
      RST = 1'b0;
      idle();
      RA_Addr = 5'd6; RA_Use = 1'b1;
      #1;
      chk("mid_ra", ra1, 32'h0);
      chk("mid_st", {31'b0, st1}, 32'h0);
      chk("mid_ierr", {31'b0, ie1}, 32'h0);

      // issue while stalled is dropped
      idle();
      Issue_En = 1'b1; Issue_Dst = 5'd11;
      tick();
      idle();
      RA_Addr = 5'd11; RA_Use = 1'b1;
      Issue_En = 1'b1; Issue_Dst = 5'd12;
      #1;
      chk("blk_st", {31'b0, st1}, 32'h1);
      tick();
      idle();
      RB_Addr = 5'd12; RB_Use = 1'b1;
      #1;
      chk("blk_dropped", {31'b0, st1}, 32'h0);
      chk("blk_dropped0", {31'b0, st0}, 32'h0);

      idle();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
